// File: rtl/wb_commit_unit.sv
// ---------------------------------------------------------------------------
// wb_commit_unit
//
// Writeback / commit stage at the end of the MEM->WB pipeline register.
// Takes the registered MEM/WB fields, decodes the destination register and
// the write-data source, and commits the result into a 32 x 32-bit GPR file.
// The GPR file has two combinational read ports for ID, with same-cycle
// bypass of the value being committed. The unit also keeps a retire counter
// and buffers every committed write in a trace FIFO. The FIFO drains through
// a valid/ready port to the debug/trace logger.
//
// Parameters
//   TRACE_DEPTH  trace FIFO entries (power of two, 2..64)
//   RESET_PC     PC held by the pipeline while it issues the reset bubble
//
// Ports
//   clk           in   1   clock; all state updates on the rising edge
//   reset         in   1   asynchronous, active-low reset
//   Instr_34      in   32  committing instruction (all-zero = bubble)
//   PC_34         in   32  PC of the committing instruction
//   DM_RD_34      in   32  data-memory read data (lw)
//   ALU_Out_34    in   32  ALU result
//   PC4_34        in   32  link value for jal / jalr
//   RegWrite_34   in   1   register write enable from control
//   RA1, RA2      in   5   ID read addresses
//   RD1, RD2      out  32  ID read data (combinational, bypassed)
//   trace_valid   out  1   trace FIFO head entry is valid
//   trace_ready   in   1   trace consumer accepts the head entry
//   trace_pc      out  32  head entry PC
//   trace_reg     out  5   head entry destination register
//   trace_data    out  32  head entry written value
//   trace_ovf     out  1   sticky: a commit was dropped because the FIFO was full
//   retire_cnt    out  32  instructions retired since reset
// ---------------------------------------------------------------------------
module wb_commit_unit #(
    parameter int          TRACE_DEPTH = 8,
    parameter logic [31:0] RESET_PC    = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_34,
    input  logic [31:0] PC_34,
    input  logic [31:0] DM_RD_34,
    input  logic [31:0] ALU_Out_34,
    input  logic [31:0] PC4_34,
    input  logic        RegWrite_34,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_reg,
    output logic [31:0] trace_data,
    output logic        trace_ovf,
    output logic [31:0] retire_cnt
);

    // Pointer width indexes TRACE_DEPTH entries. The count is one bit wider
    // so that "full" (count == TRACE_DEPTH) differs from "empty" (count == 0).
    localparam int PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TRACE_DEPTH);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] FN_JALR    = 6'h09;

    // Source of the value written back.
    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_LINK = 2'd2
    } wb_src_t;

    // -----------------------------------------------------------------------
    // Decode: destination register and write-data source
    // -----------------------------------------------------------------------
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  dest;
    wb_src_t     src;
    logic [31:0] wdata;
    logic        we;

    assign op = Instr_34[31:26];
    assign fn = Instr_34[5:0];

    // NOTE: combinational blocks assign every output a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        dest = Instr_34[20:16];
        src  = SRC_ALU;
        case (op)
            OP_SPECIAL: begin
                dest = Instr_34[15:11];
                if (fn == FN_JALR) begin
                    src = SRC_LINK;
                end
            end
            OP_LW: begin
                src = SRC_MEM;
            end
            OP_JAL: begin
                dest = 5'd31;
                src  = SRC_LINK;
            end
            default: ;
        endcase
    end

    always_comb begin
        wdata = ALU_Out_34;
        case (src)
            SRC_MEM:  wdata = DM_RD_34;
            SRC_LINK: wdata = PC4_34;
            default:  wdata = ALU_Out_34;
        endcase
    end

    // Writes to $0 are suppressed here, so GPR[0] never leaves its reset value.
    assign we = RegWrite_34 && (dest != 5'd0);

    // -----------------------------------------------------------------------
    // GPR file
    // -----------------------------------------------------------------------
    logic [31:0] gpr [32];

    // NOTE: the register file is built from resettable flops, not a RAM
    // macro, because every GPR must read as zero straight after reset.
    // Sequential state always uses non-blocking assignments.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (we) begin
            gpr[dest] <= wdata;
        end
    end

    // Read ports: $0 is hard zero. A read that hits the register being
    // committed this cycle returns the new value, so ID never sees stale data.
    always_comb begin
        RD1 = gpr[RA1];
        if (RA1 == 5'd0) begin
            RD1 = '0;
        end else if (we && (RA1 == dest)) begin
            RD1 = wdata;
        end
    end

    always_comb begin
        RD2 = gpr[RA2];
        if (RA2 == 5'd0) begin
            RD2 = '0;
        end else if (we && (RA2 == dest)) begin
            RD2 = wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Retire counter
    // -----------------------------------------------------------------------
    // The reset bubble (PC parked at RESET_PC with a null instruction) is one
    // case of the general null-instruction bubble. Neither kind retires.
    logic reset_bubble;
    logic bubble;

    assign reset_bubble = (PC_34 == RESET_PC) && (Instr_34 == 32'h0);
    assign bubble       = (Instr_34 == 32'h0) || reset_bubble;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt <= '0;
        end else if (!bubble) begin
            retire_cnt <= retire_cnt + 32'd1;   // wraps silently
        end
    end

    // -----------------------------------------------------------------------
    // Trace FIFO
    // -----------------------------------------------------------------------
    logic [31:0]   pc_mem   [TRACE_DEPTH];
    logic [4:0]    reg_mem  [TRACE_DEPTH];
    logic [31:0]   data_mem [TRACE_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          push;

    assign trace_valid = (count != '0);
    assign full        = (count == DEPTH_C);
    assign pop         = trace_valid && trace_ready;
    // When the FIFO is full, a pop in the same cycle frees the head slot. That
    // slot is the one wr_ptr points at, so the new commit still fits.
    assign push        = we && (!full || pop);

    // The payload storage is not reset. An empty FIFO never exposes it,
    // because the outputs below are zeroed whenever no entry is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= PC_34;
            reg_mem[wr_ptr]  <= dest;
            data_mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_ovf <= 1'b0;
        end else if (we && full && !pop) begin
            trace_ovf <= 1'b1;
        end
    end

    // Head entry is registered storage, so an entry appears one cycle after
    // its push and holds while the consumer stalls.
    assign trace_pc   = trace_valid ? pc_mem[rd_ptr]   : 32'h0;
    assign trace_reg  = trace_valid ? reg_mem[rd_ptr]  : 5'h0;
    assign trace_data = trace_valid ? data_mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_wb_commit_unit.sv
// ---------------------------------------------------------------------------
// tb_wb_commit_unit
//
// Self-checking bench for wb_commit_unit. The reference model holds an
// architectural register array, a queue of trace records, an overflow flag
// and a retire count, all updated from the decode/commit rules. Directed
// sequences cover reset, bypass, link/load writeback, $0 writes, FIFO
// overflow and full-FIFO push+pop. A randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_wb_commit_unit;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_34, PC_34, DM_RD_34, ALU_Out_34, PC4_34;
    logic        RegWrite_34;
    logic [4:0]  RA1, RA2;
    logic [31:0] RD1, RD2;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_reg;
    logic [31:0] trace_data;
    logic        trace_ovf;
    logic [31:0] retire_cnt;

    always #5 clk = ~clk;

    wb_commit_unit #(
        .TRACE_DEPTH(D),
        .RESET_PC   (32'h0000_3000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr_34   (Instr_34),
        .PC_34      (PC_34),
        .DM_RD_34   (DM_RD_34),
        .ALU_Out_34 (ALU_Out_34),
        .PC4_34     (PC4_34),
        .RegWrite_34(RegWrite_34),
        .RA1        (RA1),
        .RA2        (RA2),
        .RD1        (RD1),
        .RD2        (RD2),
        .trace_valid(trace_valid),
        .trace_ready(trace_ready),
        .trace_pc   (trace_pc),
        .trace_reg  (trace_reg),
        .trace_data (trace_data),
        .trace_ovf  (trace_ovf),
        .retire_cnt (retire_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } trace_t;

    trace_t      m_q[$];
    logic [31:0] m_gpr [32];
    logic        m_ovf;
    logic [31:0] m_ret;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_ovf = 1'b0;
        m_ret = 32'h0;
    endtask

    // Destination and value of the current instruction, from the opcode rules.
    task automatic ref_decode(output logic [4:0] d, output logic [31:0] v);
        logic [5:0] op;
        op = Instr_34[31:26];
        if (op == 6'h00 && Instr_34[5:0] == 6'h09) begin d = Instr_34[15:11]; v = PC4_34;     end
        else if (op == 6'h00)                      begin d = Instr_34[15:11]; v = ALU_Out_34; end
        else if (op == 6'h23)                      begin d = Instr_34[20:16]; v = DM_RD_34;   end
        else if (op == 6'h03)                      begin d = 5'd31;           v = PC4_34;     end
        else                                       begin d = Instr_34[20:16]; v = ALU_Out_34; end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] ra, input logic w,
                                             input logic [4:0] d, input logic [31:0] v);
        if (ra == 5'd0)      return 32'h0;
        if (w && ra == d)    return v;
        return m_gpr[ra];
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] dm,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic rw);
        Instr_34    = instr;
        PC_34       = pc;
        DM_RD_34    = dm;
        ALU_Out_34  = alu;
        PC4_34      = pc4;
        RegWrite_34 = rw;
    endtask

    // Called just after a falling edge with inputs driven. Checks every output
    // against the model, advances both across one rising edge, and returns at
    // the next falling edge.
    task automatic tick(input string tag);
        logic [4:0]  d;
        logic [31:0] v;
        logic        w;
        trace_t      e;
        ref_decode(d, v);
        w = RegWrite_34 && (d != 5'd0);
        #1;
        check({tag, "/rd1"},   RD1, ref_read(RA1, w, d, v));
        check({tag, "/rd2"},   RD2, ref_read(RA2, w, d, v));
        check({tag, "/valid"}, 32'(trace_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            e = m_q[0];
            check({tag, "/tpc"},   trace_pc,          e.pc);
            check({tag, "/treg"},  32'(trace_reg),    32'(e.rd));
            check({tag, "/tdata"}, trace_data,        e.data);
        end else begin
            check({tag, "/tzero"}, trace_pc | trace_data | 32'(trace_reg), 32'h0);
        end
        check({tag, "/retire"}, retire_cnt,     m_ret);
        check({tag, "/ovf"},    32'(trace_ovf), 32'(m_ovf));
        @(posedge clk);
        if (trace_ready && m_q.size() != 0) void'(m_q.pop_front());
        if (w) begin
            m_gpr[d] = v;
            if (m_q.size() < D) m_q.push_back('{pc: PC_34, rd: d, data: v});
            else                m_ovf = 1'b1;
        end
        if (Instr_34 != 32'h0) m_ret = m_ret + 32'd1;
        @(negedge clk);
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rt, input logic [15:0] imm);
        return {6'h08, 5'd0, rt, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return {6'h00, r[25:11], 5'd0, ($urandom_range(0, 1) == 1) ? 6'h09 : 6'h21};
            2:       return {6'h23, r[25:0]};
            3:       return {6'h03, r[25:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        RA1 = 5'd0;
        RA2 = 5'd0;
        trace_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tick("reset_state");

        // 10 bubbles (RegWrite noise only), then 4 real non-writing instructions.
        for (int i = 0; i < 10; i++) begin
            drive(32'h0, 32'h3000, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
            RA1 = 5'($urandom);
            tick("bubble");
        end
        for (int i = 0; i < 4; i++) begin
            drive(32'h3C00_0001 + 32'(i), 32'h3000 + 32'(4 * i), 32'h0, 32'h9999, 32'h0, 1'b1);
            tick("lui_r0");
        end
        check("t6_retire", retire_cnt, 32'd4);
        check("t6_no_trace", 32'(trace_valid), 32'd0);

        // ori $8 with same-cycle bypass, then read back from the register file.
        drive(32'h3408_1234, 32'h3004, 32'h0, 32'h1234, 32'h300C, 1'b1);
        RA1 = 5'd8;
        #1 check("t2_bypass", RD1, 32'h1234);
        tick("t2_ori");
        drive(32'h0, 32'h3008, 32'h0, 32'h0, 32'h0, 1'b0);
        #1 check("t2_gpr", RD1, 32'h1234);
        check("t2_trace_pc", trace_pc, 32'h3004);
        check("t2_trace_reg", 32'(trace_reg), 32'd8);
        check("t2_trace_data", trace_data, 32'h1234);
        tick("t2_idle");

        // jal, lw, and an R-type whose destination is $0.
        drive(32'h0C00_0C04, 32'h3010, 32'h0, 32'hAAAA_0000, 32'h3018, 1'b1);
        tick("t3_jal");
        drive(32'h8C09_0000, 32'h3014, 32'hDEAD_BEEF, 32'h55, 32'h301C, 1'b1);
        RA1 = 5'd31;
        #1 check("t3_gpr31", RD1, 32'h3018);
        tick("t3_lw");
        drive(32'h0000_0021, 32'h3018, 32'h0, 32'h7777, 32'h0, 1'b1);
        RA1 = 5'd9;
        RA2 = 5'd0;
        #1 check("t3_gpr9", RD1, 32'hDEAD_BEEF);
        check("t3_gpr0", RD2, 32'h0);
        tick("t3_r0");
        check("t3_retire", retire_cnt, 32'd8);

        // Drain the three queued entries (ori, jal, lw).
        trace_ready = 1'b1;
        drive(32'h0, 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick("drain1");

        // Fill to 8, then push and pop together while full.
        trace_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            drive(addi(5'(i), 16'(i)), 32'h4000 + 32'(4 * i), 32'h0, 32'h100 + 32'(i), 32'h0, 1'b1);
            RA1 = 5'(i);
            tick("t5_fill");
        end
        trace_ready = 1'b1;
        drive(addi(5'd12, 16'h0C), 32'h4040, 32'h0, 32'h10C, 32'h0, 1'b1);
        tick("t5_pushpop");
        check("t5_ovf", 32'(trace_ovf), 32'd0);
        trace_ready = 1'b0;
        drive(32'h0, 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0);
        tick("t5_hold");
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick("t5_drain");
        check("t5_empty", 32'(trace_valid), 32'd0);

        // Nine commits into an 8-deep FIFO with the consumer stalled.
        trace_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(addi(5'(16 + i), 16'(i)), 32'h5000 + 32'(4 * i), 32'h0, 32'hA000 + 32'(i), 32'h0, 1'b1);
            tick("t4_fill");
        end
        check("t4_ovf", 32'(trace_ovf), 32'd1);
        check("t4_head", trace_data, 32'hA000);
        trace_ready = 1'b1;
        drive(32'h0, 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) tick("t4_drain");
        check("t4_empty", 32'(trace_valid), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(rand_instr(), $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 3) != 0));
            RA1 = ($urandom_range(0, 3) == 0) ? Instr_34[20:16] : 5'($urandom);
            RA2 = ($urandom_range(0, 3) == 0) ? Instr_34[15:11] : 5'($urandom);
            trace_ready = 1'($urandom_range(0, 2) != 0);
            tick("rand");
        end

        // Asynchronous reset in the middle of a cycle with entries queued.
        trace_ready = 1'b0;
        drive(addi(5'd5, 16'h0005), 32'h6000, 32'h0, 32'hCAFE_0005, 32'h0, 1'b1);
        tick("t1_w5");
        drive(addi(5'd6, 16'h0006), 32'h6004, 32'h0, 32'hCAFE_0006, 32'h0, 1'b1);
        tick("t1_w6");
        drive(addi(5'd7, 16'h0007), 32'h6008, 32'h0, 32'hCAFE_0007, 32'h0, 1'b1);
        tick("t1_w7");
        drive(32'h0, 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0);
        RA1 = 5'd5;
        #1 check("t1_pre_rd1", RD1, 32'hCAFE_0005);
        #1 reset = 1'b0;
        #1;
        check("t1_valid", 32'(trace_valid), 32'd0);
        check("t1_rd1", RD1, 32'h0);
        check("t1_retire", retire_cnt, 32'd0);
        check("t1_ovf", 32'(trace_ovf), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick("post_reset");
        drive(addi(5'd5, 16'h0055), 32'h7000, 32'h0, 32'h55, 32'h0, 1'b1);
        tick("post_reset_w");
        drive(32'h0, 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0);
        tick("post_reset_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
